// File: rtl/vector_store_unit_pkg.sv
// Shared definitions for the vector load/store paths: vector geometry,
// the store FSM state type and the lane-select helper.
package vector_store_unit_pkg;

    localparam int LANE_W = 16;
    localparam int LANES  = 16;
    localparam int VEC_W  = LANES * LANE_W;
    localparam int IDX_W  = $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Lane i occupies bits [LANE_W*i +: LANE_W] of the packed vector.
    function automatic logic [LANE_W-1:0] lane_sel(input logic [VEC_W-1:0] vec,
                                                   input logic [IDX_W-1:0] idx);
        return vec[idx*LANE_W +: LANE_W];
    endfunction

endpackage

// File: rtl/vector_store_unit.sv
// Serializes one latched 256-bit vector onto the 16-bit data memory port,
// one lane per accepted write, lane 0 first, with per-lane write masking.
module vector_store_unit #(
    parameter int LANES  = 16,
    parameter int LANE_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [LANES*LANE_W-1:0] vec_data,
    input  logic [LANES-1:0]        lane_mask,
    input  logic                    mem_ready,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [LANE_W-1:0]       mem_wdata,
    output logic                    busy,
    output logic                    done
);
    import vector_store_unit_pkg::*;

    localparam int              CNT_W = $clog2(LANES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

    state_t                  state, state_nx;
    logic [CNT_W-1:0]        idx, idx_nx;
    logic                    load;
    logic [ADDR_W-1:0]       base_p0;
    logic [LANES*LANE_W-1:0] vec_p0;
    logic [LANES-1:0]        mask_p0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    // Captured operands: only meaningful once WRITE is entered, so no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            base_p0 <= base_addr;
            vec_p0  <= vec_data;
            mask_p0 <= lane_mask;
        end
    end

    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        load      = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    idx_nx   = '0;
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                busy      = 1'b1;
                mem_addr  = base_p0 + {{(ADDR_W-CNT_W){1'b0}}, idx};
                mem_wdata = lane_sel(vec_p0, idx);
                mem_we    = mask_p0[idx];
                // A masked lane never waits on mem_ready; a live one waits for acceptance.
                if (!mask_p0[idx] || mem_ready) begin
                    idx_nx = idx + CNT_W'(1);
                    if (idx == LAST)
                        state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_vector_store_unit.sv
// Scoreboard bench for vector_store_unit: stimulus queues expected writes and
// done pulses with their cycle numbers, a negedge monitor pops and compares.
module tb_vector_store_unit;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [15:0]  base_addr;
    logic [255:0] vec_data;
    logic [15:0]  lane_mask;
    logic         mem_ready;
    logic         mem_we;
    logic [15:0]  mem_addr;
    logic [15:0]  mem_wdata;
    logic         busy;
    logic         done;

    vector_store_unit #(.LANES(16), .LANE_W(16), .ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .vec_data(vec_data), .lane_mask(lane_mask), .mem_ready(mem_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    wr_t wq[$];
    int  dq[$];
    int  total = 0;
    int  bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: accepted writes, done pulses and stall stability.
    wr_t         mon_e;
    int          mon_d;
    logic        prev_pend = 1'b0;
    logic [15:0] prev_addr = '0;
    logic [15:0] prev_data = '0;

    always @(negedge clk) begin
        if (rst_n && prev_pend) begin
            chk("stall_hold_we",   {31'd0, mem_we}, 32'd1);
            chk("stall_hold_addr", {16'd0, mem_addr}, {16'd0, prev_addr});
            chk("stall_hold_data", {16'd0, mem_wdata}, {16'd0, prev_data});
        end
        if (rst_n && mem_we && mem_ready) begin
            if (wq.size() == 0) begin
                chk("queued_writes", wq.size(), 32'd1);
            end else begin
                mon_e = wq.pop_front();
                chk("wr_addr", {16'd0, mem_addr}, {16'd0, mon_e.addr});
                chk("wr_data", {16'd0, mem_wdata}, {16'd0, mon_e.data});
                chk("wr_cycle", cyc, mon_e.cyc);
                chk("busy_on_write", {31'd0, busy}, 32'd1);
            end
        end
        if (rst_n && done) begin
            if (dq.size() == 0) begin
                chk("queued_done", dq.size(), 32'd1);
            end else begin
                mon_d = dq.pop_front();
                chk("done_cycle", cyc, mon_d);
                chk("busy_at_done", {31'd0, busy}, 32'd0);
                chk("we_at_done", {31'd0, mem_we}, 32'd0);
            end
        end
        prev_pend = rst_n && mem_we && !mem_ready;
        prev_addr = mem_addr;
        prev_data = mem_wdata;
    end

    function automatic logic [255:0] mk_vec(input logic [15:0] first);
        logic [255:0] v;
        for (int i = 0; i < 16; i++) v[i*16 +: 16] = first + 16'(i);
        return v;
    endfunction

    // Called at #1 after a posedge; returns at #1 after the accepting edge.
    // stall_lane gets three extra wait cycles in the expected timeline.
    task automatic issue(input logic [15:0] base, input logic [15:0] first,
                         input logic [15:0] mask, input int stall_lane);
        int c;
        c = cyc + 1;
        for (int i = 0; i < 16; i++) begin
            if (mask[i]) begin
                if (i == stall_lane) c += 3;
                wq.push_back('{addr: base + 16'(i), data: first + 16'(i), cyc: c});
            end
            c++;
        end
        dq.push_back(c);
        base_addr = base;
        vec_data  = mk_vec(first);
        lane_mask = mask;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        base_addr = 16'hDEAD;
        vec_data  = mk_vec(16'h7700);
        lane_mask = ~mask;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((wq.size() != 0 || dq.size() != 0) && k < 60) begin
            @(posedge clk);
            k++;
        end
        chk("drain_pending", wq.size() + dq.size(), 32'd0);
        wq.delete();
        dq.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: cycle %0d reached limit", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; vec_data = '0;
        lane_mask = '0; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        start = 1'b1;
        @(negedge clk);
        chk("rst_we",    {31'd0, mem_we}, 32'd0);
        chk("rst_addr",  {16'd0, mem_addr}, 32'd0);
        chk("rst_wdata", {16'd0, mem_wdata}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full store, no stall.
        issue(16'h0100, 16'h3C00, 16'hFFFF, -1);
        @(negedge clk);
        chk("busy_first_write_cycle", {31'd0, busy}, 32'd1);
        drain();

        // Stall three cycles on lane 5 (lane 5 visible at T+6).
        issue(16'h0100, 16'h3C00, 16'hFFFF, 5);
        repeat (5) @(posedge clk);
        #1 mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 mem_ready = 1'b1;
        drain();

        // Sparse and empty masks.
        issue(16'h0200, 16'h1000, 16'h8001, -1);
        drain();
        mem_ready = 1'b0;
        issue(16'h0280, 16'h2000, 16'h0000, -1);
        drain();
        mem_ready = 1'b1;

        // Address wrap.
        issue(16'hFFFE, 16'hA000, 16'hFFFF, -1);
        drain();

        // Second start while busy is ignored.
        issue(16'h0400, 16'h5000, 16'hFFFF, -1);
        repeat (4) @(posedge clk);
        #1;
        base_addr = 16'h0900; vec_data = mk_vec(16'h6600); lane_mask = 16'hFFFF;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drain();

        // Reset while lane 7 is presented (held unaccepted).
        issue(16'h0300, 16'hB000, 16'hFFFF, -1);
        repeat (7) @(posedge clk);
        #1;
        mem_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        chk("abort_lanes_left", wq.size(), 32'd9);
        wq.delete();
        dq.delete();
        @(negedge clk);
        chk("abort_we",    {31'd0, mem_we}, 32'd0);
        chk("abort_addr",  {16'd0, mem_addr}, 32'd0);
        chk("abort_wdata", {16'd0, mem_wdata}, 32'd0);
        chk("abort_busy",  {31'd0, busy}, 32'd0);
        chk("abort_done",  {31'd0, done}, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        issue(16'h0500, 16'hC000, 16'hFFFF, -1);
        drain();

        chk("final_writes_left", wq.size(), 32'd0);
        chk("final_done_left", dq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vector_store_unit.md
Name: vector_store_unit

Overview:
- Multi-cycle serializer for the store path. It latches one 256-bit vector (16 lanes of 16-bit half-precision or integer data), as produced by the ALU or read from a vector register.
- It writes the lanes to the 16-bit data memory one lane per accepted transfer.
- It is the writer-side counterpart of the vector load path, sitting between the register file/ALU result bus and the data memory port.
- Lane write enables are per-lane maskable.

Parameters:
- LANES, 16, number of lanes per vector
- LANE_W, 16, bits per lane; vector width = LANES*LANE_W = 256
- ADDR_W, 16, memory word-address width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active low
- start  in  1  request a vector store; sampled only in IDLE
- base_addr  in  ADDR_W  word address of lane 0; latched on accepted start
- vec_data  in  256  vector to store; lane i = bits [16i+15:16i]; latched on accepted start
- lane_mask  in  LANES  bit i = 1 writes lane i; latched on accepted start
- mem_ready  in  1  memory accepts the current write this cycle
- mem_we  out  1  write request for the current lane
- mem_addr  out  ADDR_W  target word address
- mem_wdata  out  LANE_W  lane data
- busy  out  1  high in WRITE state
- done  out  1  one-cycle pulse on completion

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-low (rst_n).
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, state=IDLE, lane counter=0.
- Reset mid-operation aborts immediately. No further writes occur, and no done pulse is issued.
- States:
  - IDLE: outputs low. If start=1, latch base_addr, vec_data and lane_mask, clear the lane index, and go to WRITE.
  - WRITE: busy=1. mem_addr = latched base + lane index, modulo 2^ADDR_W (wraps at 0xFFFF -> 0x0000). mem_wdata = latched lane[index]. mem_we = mask[index].
    - The lane advances when mask[index]=0 (a skipped lane costs exactly one cycle, mem_we=0) or when mem_we & mem_ready.
    - While mem_we=1 and mem_ready=0, hold all outputs stable (no data/address change while a request is pending).
    - When lane LANES-1 advances, go to DONE.
  - DONE: busy=0, mem_we=0, done=1 for exactly one cycle, then IDLE.
- start is ignored in WRITE and DONE. It is not queued.
- A new start in the cycle after DONE (i.e. in IDLE) is accepted normally, so back-to-back stores have a 1-cycle IDLE gap minimum.
- Latency with mask=0xFFFF and mem_ready tied high:
  - start accepted at cycle T.
  - Lane i is written at cycle T+1+i.
  - done at T+17.
- All-zero mask: 16 WRITE cycles with mem_we=0, then a done pulse at T+17. No memory writes.
- Inputs vec_data, base_addr and lane_mask may change freely after start is accepted. Only the latched copies are used.
- mem_ready is ignored whenever mem_we=0.
- Write order is always lane 0 to lane 15, ascending addresses.

Decomposition:
- Shared package holds:
  - VEC_W=256, LANE_W=16, LANES=16.
  - The state enum {IDLE, WRITE, DONE}.
  - The lane-select helper that returns lane i of a 256-bit vector, shared with the vector load path.
- Implement as a single module. No sub-module is needed: the datapath (address adder, lane mux, counter) is small and tightly coupled to the FSM.

Test Plan:
- Full store, no stall: base=0x0100, mask=0xFFFF, vec lane i = 0x3C00+i, mem_ready=1 -> writes 0x0100..0x010F with data 0x3C00..0x3C0F at T+1..T+16; done pulses at T+17; busy high T+1..T+16.
- Stall: same vector, mem_ready low for 3 cycles on lane 5 -> mem_we/mem_addr=0x0105/mem_wdata=0x3C05 held stable for 4 cycles; done at T+20.
- Masking: mask=0x8001 -> exactly two writes, lane 0 at base and lane 15 at base+15; done at T+17. Mask=0x0000 -> zero writes, done at T+17.
- Address wrap: base=0xFFFE, mask=0xFFFF -> addresses 0xFFFE, 0xFFFF, 0x0000..0x000D.
- start while busy: second start at T+5 with different data -> ignored; only the first vector is written; exactly one done pulse.
- Reset mid-operation: rst_n low at lane 7 -> next cycle all outputs 0, state IDLE, no done pulse. A new start after reset completes a full 16-lane store correctly.
